// File: rtl/tx_bridge_mux.sv
// Multi-channel PCIe transmit bridge. It arbitrates header/data stream pairs round-robin,
// rewrites the request fmt/type byte to the completion encoding and frames the result onto one registered output stream.
module tx_bridge_mux #(
  parameter int DATA_W = 64,
  parameter int KEEP_W = DATA_W / 8,
  parameter int NUM_CH = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_CH-1:0]        hdr_valid,
  output logic [NUM_CH-1:0]        hdr_ready,
  input  logic [NUM_CH*DATA_W-1:0] hdr_data,
  input  logic [NUM_CH*KEEP_W-1:0] hdr_keep,
  input  logic [NUM_CH-1:0]        hdr_last,
  input  logic [NUM_CH-1:0]        dat_valid,
  output logic [NUM_CH-1:0]        dat_ready,
  input  logic [NUM_CH*DATA_W-1:0] dat_data,
  input  logic [NUM_CH*KEEP_W-1:0] dat_keep,
  input  logic [NUM_CH-1:0]        dat_last,
  output logic                     axi_out_valid,
  input  logic                     axi_out_ready,
  output logic [DATA_W-1:0]        axi_out_data,
  output logic [KEEP_W-1:0]        axi_out_keep,
  output logic                     axi_out_last,
  output logic                     err_unsup,
  output logic                     err_len
);
  localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CW = $clog2(KEEP_W + 1);

  typedef enum logic [1:0] {IDLE, HDR, DATA, DROP} state_t;

  state_t              state_reg;
  logic [GW-1:0]       grant_reg;
  logic                first_reg;
  logic                has_data_reg;
  logic [10:0]         exp_cnt_reg;
  logic [10:0]         dw_cnt_reg;
  logic                out_valid_reg;
  logic                out_last_reg;
  logic [DATA_W-1:0]   out_data_reg;
  logic [KEEP_W-1:0]   out_keep_reg;
  logic                err_unsup_reg;
  logic                err_len_reg;

  logic [DATA_W-1:0]   hdr_data_ch [NUM_CH];
  logic [KEEP_W-1:0]   hdr_keep_ch [NUM_CH];
  logic [DATA_W-1:0]   dat_data_ch [NUM_CH];
  logic [KEEP_W-1:0]   dat_keep_ch [NUM_CH];

  logic                stage_en;
  logic                hdr_rdy_g;
  logic                dat_rdy_g;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign hdr_data_ch[gi] = hdr_data[gi*DATA_W +: DATA_W];
      assign hdr_keep_ch[gi] = hdr_keep[gi*KEEP_W +: KEEP_W];
      assign dat_data_ch[gi] = dat_data[gi*DATA_W +: DATA_W];
      assign dat_keep_ch[gi] = dat_keep[gi*KEEP_W +: KEEP_W];
      assign hdr_ready[gi]   = (grant_reg == GW'(gi)) && hdr_rdy_g;
      assign dat_ready[gi]   = (grant_reg == GW'(gi)) && dat_rdy_g;
    end
  endgenerate

  function automatic logic fmt_supported(input logic [7:0] b);
    return (b == 8'h00) || (b == 8'h20) || (b == 8'h01) ||
           (b == 8'h21) || (b == 8'h40) || (b == 8'h60);
  endfunction

  function automatic logic [7:0] fmt_xlate(input logic [7:0] b);
    case (b)
      8'h00:   return 8'h4A;
      8'h20:   return 8'h6A;
      8'h01:   return 8'h4B;
      8'h21:   return 8'h6B;
      8'h40:   return 8'h0A;
      8'h60:   return 8'h2A;
      default: return b;
    endcase
  endfunction

  logic                g_hdr_valid, g_hdr_last, g_dat_valid, g_dat_last;
  logic [DATA_W-1:0]   g_hdr_data, g_dat_data;
  logic [KEEP_W-1:0]   g_hdr_keep, g_dat_keep;

  assign g_hdr_valid = hdr_valid[grant_reg];
  assign g_hdr_last  = hdr_last[grant_reg];
  assign g_hdr_data  = hdr_data_ch[grant_reg];
  assign g_hdr_keep  = hdr_keep_ch[grant_reg];
  assign g_dat_valid = dat_valid[grant_reg];
  assign g_dat_last  = dat_last[grant_reg];
  assign g_dat_data  = dat_data_ch[grant_reg];
  assign g_dat_keep  = dat_keep_ch[grant_reg];

  assign stage_en  = !out_valid_reg || axi_out_ready;
  // DROP discards header beats without touching the output stage, so it never waits on it.
  assign hdr_rdy_g = ((state_reg == HDR) && stage_en) || (state_reg == DROP);
  assign dat_rdy_g = (state_reg == DATA) && stage_en;

  logic hdr_acc, hdr_fwd, dat_acc;
  assign hdr_acc = hdr_rdy_g && g_hdr_valid;
  assign hdr_fwd = hdr_acc && (state_reg == HDR);
  assign dat_acc = dat_rdy_g && g_dat_valid;

  // Round-robin search starting just after the previous grant.
  logic [GW-1:0] arb_sel;
  logic          arb_found;
  always_comb begin
    arb_found = 1'b0;
    arb_sel   = grant_reg;
    for (int i = 1; i <= NUM_CH; i++) begin
      if (!arb_found && hdr_valid[(int'(grant_reg) + i) % NUM_CH]) begin
        arb_found = 1'b1;
        arb_sel   = GW'((int'(grant_reg) + i) % NUM_CH);
      end
    end
  end

  logic [7:0]        sel_byte;
  logic [7:0]        hdr_tbyte;
  logic [DATA_W-1:0] hdr_out_data;
  logic              hdr_dp;
  assign sel_byte     = hdr_data_ch[arb_sel][31:24];
  assign hdr_tbyte    = fmt_xlate(g_hdr_data[31:24]);
  assign hdr_out_data = first_reg ? {g_hdr_data[DATA_W-1:32], hdr_tbyte, g_hdr_data[23:0]}
                                  : g_hdr_data;
  assign hdr_dp       = first_reg ? hdr_tbyte[6] : has_data_reg;

  logic [CW-1:0] keep_ones;
  logic [10:0]   dw_sum;
  always_comb begin
    keep_ones = '0;
    for (int i = 0; i < KEEP_W; i++) keep_ones = keep_ones + CW'(g_dat_keep[i]);
  end
  assign dw_sum = dw_cnt_reg + 11'(keep_ones >> 2);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      grant_reg     <= GW'(NUM_CH - 1);
      first_reg     <= 1'b0;
      has_data_reg  <= 1'b0;
      exp_cnt_reg   <= '0;
      dw_cnt_reg    <= '0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      out_data_reg  <= '0;
      out_keep_reg  <= '0;
      err_unsup_reg <= 1'b0;
      err_len_reg   <= 1'b0;
    end else begin
      err_unsup_reg <= 1'b0;
      err_len_reg   <= 1'b0;
      if (stage_en) out_valid_reg <= hdr_fwd || dat_acc;
      case (state_reg)
        IDLE: begin
          if (arb_found) begin
            grant_reg  <= arb_sel;
            first_reg  <= 1'b1;
            dw_cnt_reg <= '0;
            // The first header beat is already stable, so unsupported packets are routed to DROP here.
            state_reg  <= fmt_supported(sel_byte) ? HDR : DROP;
          end
        end
        HDR: begin
          if (hdr_fwd) begin
            out_data_reg <= hdr_out_data;
            out_keep_reg <= g_hdr_keep;
            out_last_reg <= g_hdr_last && !hdr_dp;
            first_reg    <= 1'b0;
            if (first_reg) begin
              has_data_reg <= hdr_tbyte[6];
              exp_cnt_reg  <= (g_hdr_data[9:0] == 10'd0) ? 11'd1024 : {1'b0, g_hdr_data[9:0]};
            end
            if (g_hdr_last) state_reg <= hdr_dp ? DATA : IDLE;
          end
        end
        DATA: begin
          if (dat_acc) begin
            out_data_reg <= g_dat_data;
            out_keep_reg <= g_dat_keep;
            out_last_reg <= g_dat_last;
            dw_cnt_reg   <= dw_sum;
            if (g_dat_last) begin
              err_len_reg <= (dw_sum != exp_cnt_reg);
              state_reg   <= IDLE;
            end
          end
        end
        DROP: begin
          if (hdr_acc && g_hdr_last) begin
            err_unsup_reg <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign axi_out_valid = out_valid_reg;
  assign axi_out_data  = out_data_reg;
  assign axi_out_keep  = out_keep_reg;
  assign axi_out_last  = out_last_reg;
  assign err_unsup     = err_unsup_reg;
  assign err_len       = err_len_reg;
endmodule

// File: tb/tb_tx_bridge_mux.sv
// Directed bench for tx_bridge_mux: a per-cycle vector table on a 64-bit instance plus
// hand sequences on a 128-bit instance for length error, mid-packet reset and pointer reset.
module tb_tx_bridge_mux;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [1:0]   hv, hr, hl, dv, dr, dl;
  logic [127:0] hd, dd;
  logic [15:0]  hk, dk;
  logic         ordy, ov, ol, eu, el;
  logic [63:0]  od;
  logic [7:0]   ok;

  logic         rst2_n;
  logic [1:0]   hv2, hr2, hl2, dv2, dr2, dl2;
  logic [255:0] hd2, dd2;
  logic [31:0]  hk2, dk2;
  logic         ordy2, ov2, ol2, eu2, el2;
  logic [127:0] od2;
  logic [15:0]  ok2;

  tx_bridge_mux #(.DATA_W(64), .NUM_CH(2)) u_dut64 (
    .clk(clk), .reset_n(rst_n),
    .hdr_valid(hv), .hdr_ready(hr), .hdr_data(hd), .hdr_keep(hk), .hdr_last(hl),
    .dat_valid(dv), .dat_ready(dr), .dat_data(dd), .dat_keep(dk), .dat_last(dl),
    .axi_out_valid(ov), .axi_out_ready(ordy), .axi_out_data(od), .axi_out_keep(ok),
    .axi_out_last(ol), .err_unsup(eu), .err_len(el)
  );

  tx_bridge_mux #(.DATA_W(128), .NUM_CH(2)) u_dut128 (
    .clk(clk), .reset_n(rst2_n),
    .hdr_valid(hv2), .hdr_ready(hr2), .hdr_data(hd2), .hdr_keep(hk2), .hdr_last(hl2),
    .dat_valid(dv2), .dat_ready(dr2), .dat_data(dd2), .dat_keep(dk2), .dat_last(dl2),
    .axi_out_valid(ov2), .axi_out_ready(ordy2), .axi_out_data(od2), .axi_out_keep(ok2),
    .axi_out_last(ol2), .err_unsup(eu2), .err_len(el2)
  );

  typedef struct {
    logic [1:0]  hv, hl, dv, dl;
    logic [63:0] hd0, hd1, dd;
    logic        ordy;
    logic [1:0]  hr, dr;
    logic        ov;
    logic [63:0] od;
    logic        ol, eu, el;
  } vec_t;

  vec_t vec [40];
  int   n_rows = 0;
  int   n_vec  = 0;
  int   n_mis  = 0;

  localparam logic [63:0] A1  = 64'h1111_2222_0000_0002, A1T = 64'h1111_2222_4A00_0002;
  localparam logic [63:0] A2  = 64'h3333_4444_5555_6666, AD  = 64'hDEAD_BEEF_CAFE_F00D;
  localparam logic [63:0] B1  = 64'hAAAA_BBBB_4000_0001, B1T = 64'hAAAA_BBBB_0A00_0001;
  localparam logic [63:0] B2  = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] C0  = 64'h0000_0C00_4000_0001, C0T = 64'h0000_0C00_0A00_0001;
  localparam logic [63:0] C1  = 64'h0000_0C11_6000_0001, C1T = 64'h0000_0C11_2A00_0001;
  localparam logic [63:0] P1  = 64'h0000_0001_4000_0004, P1T = 64'h0000_0001_0A00_0004;
  localparam logic [63:0] P2  = 64'h2222_2222_2222_2222, P3  = 64'h3333_3333_3333_3333;
  localparam logic [63:0] P4  = 64'h4444_4444_4444_4444;
  localparam logic [63:0] U1  = 64'h0000_0000_1F00_0001, U2  = 64'h5A5A_5A5A_5A5A_5A5A;
  localparam logic [63:0] U3  = 64'hA5A5_A5A5_A5A5_A5A5;
  localparam logic [63:0] N1  = 64'h5555_0000_6000_0001, N1T = 64'h5555_0000_2A00_0001;

  localparam logic [127:0] H128  = 128'h0000_0000_9999_9999_7777_8888_0000_0004;
  localparam logic [127:0] H128T = 128'h0000_0000_9999_9999_7777_8888_4A00_0004;
  localparam logic [127:0] D128  = 128'h0000_0000_0000_0000_FEED_FACE_0BAD_F00D;
  localparam logic [127:0] W0    = 128'h0000_0000_0000_0000_0000_00A0_4000_0001;
  localparam logic [127:0] W0T   = 128'h0000_0000_0000_0000_0000_00A0_0A00_0001;
  localparam logic [127:0] W1    = 128'h0000_0000_0000_0000_0000_00B1_4000_0001;

  task automatic add(input logic [1:0] a_hv, input logic [1:0] a_hl, input logic [63:0] a_hd0,
                     input logic [63:0] a_hd1, input logic [1:0] a_dv, input logic [1:0] a_dl,
                     input logic [63:0] a_dd, input logic a_ordy, input logic [1:0] a_hr,
                     input logic [1:0] a_dr, input logic a_ov, input logic [63:0] a_od,
                     input logic a_ol, input logic a_eu, input logic a_el);
    vec[n_rows] = '{a_hv, a_hl, a_dv, a_dl, a_hd0, a_hd1, a_dd, a_ordy,
                    a_hr, a_dr, a_ov, a_od, a_ol, a_eu, a_el};
    n_rows++;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end else begin
      $display("ok   %s = %h", nm, act);
    end
  endtask

  initial begin
    // ch0 MRd with one data beat
    add(2'b01, 2'b00, A1, 0, 2'b00, 2'b00, 0,  1, 2'b00, 2'b00, 0, 0,   0, 0, 0);
    add(2'b01, 2'b00, A1, 0, 2'b00, 2'b00, 0,  1, 2'b01, 2'b00, 1, A1T, 0, 0, 0);
    add(2'b01, 2'b01, A2, 0, 2'b00, 2'b00, 0,  1, 2'b01, 2'b00, 1, A2,  0, 0, 0);
    add(2'b00, 2'b00, 0,  0, 2'b01, 2'b01, AD, 1, 2'b00, 2'b01, 1, AD,  1, 0, 0);
    add(2'b00, 2'b00, 0,  0, 2'b00, 2'b00, 0,  1, 2'b00, 2'b00, 0, 0,   0, 0, 0);
    // ch1 MWr, data offered but never taken
    add(2'b10, 2'b00, 0, B1, 2'b00, 2'b00, 0,  1, 2'b00, 2'b00, 0, 0,   0, 0, 0);
    add(2'b10, 2'b00, 0, B1, 2'b10, 2'b00, AD, 1, 2'b10, 2'b00, 1, B1T, 0, 0, 0);
    add(2'b10, 2'b10, 0, B2, 2'b10, 2'b00, AD, 1, 2'b10, 2'b00, 1, B2,  1, 0, 0);
    add(2'b00, 2'b00, 0, 0,  2'b00, 2'b00, 0,  1, 2'b00, 2'b00, 0, 0,   0, 0, 0);
    // both channels contending, single-beat no-data packets
    add(2'b11, 2'b11, C0, C1, 2'b00, 2'b00, 0, 1, 2'b00, 2'b00, 0, 0,   0, 0, 0);
    add(2'b11, 2'b11, C0, C1, 2'b00, 2'b00, 0, 1, 2'b01, 2'b00, 1, C0T, 1, 0, 0);
    add(2'b11, 2'b11, C0, C1, 2'b00, 2'b00, 0, 1, 2'b00, 2'b00, 0, 0,   0, 0, 0);
    add(2'b11, 2'b11, C0, C1, 2'b00, 2'b00, 0, 1, 2'b10, 2'b00, 1, C1T, 1, 0, 0);
    add(2'b11, 2'b11, C0, C1, 2'b00, 2'b00, 0, 1, 2'b00, 2'b00, 0, 0,   0, 0, 0);
    add(2'b11, 2'b11, C0, C1, 2'b00, 2'b00, 0, 1, 2'b01, 2'b00, 1, C0T, 1, 0, 0);
    add(2'b00, 2'b00, 0,  0,  2'b00, 2'b00, 0, 1, 2'b00, 2'b00, 0, 0,   0, 0, 0);
    // 4-beat header with output backpressure 1,0,0,1
    add(2'b01, 2'b00, P1, 0, 2'b00, 2'b00, 0, 1, 2'b00, 2'b00, 0, 0,   0, 0, 0);
    add(2'b01, 2'b00, P1, 0, 2'b00, 2'b00, 0, 1, 2'b01, 2'b00, 1, P1T, 0, 0, 0);
    add(2'b01, 2'b00, P2, 0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 1, P1T, 0, 0, 0);
    add(2'b01, 2'b00, P2, 0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 1, P1T, 0, 0, 0);
    add(2'b01, 2'b00, P2, 0, 2'b00, 2'b00, 0, 1, 2'b01, 2'b00, 1, P2,  0, 0, 0);
    add(2'b01, 2'b00, P3, 0, 2'b00, 2'b00, 0, 1, 2'b01, 2'b00, 1, P3,  0, 0, 0);
    add(2'b01, 2'b01, P4, 0, 2'b00, 2'b00, 0, 1, 2'b01, 2'b00, 1, P4,  1, 0, 0);
    add(2'b00, 2'b00, 0,  0, 2'b00, 2'b00, 0, 1, 2'b00, 2'b00, 0, 0,   0, 0, 0);
    // unsupported 0x1F on ch1, then a normal packet
    add(2'b10, 2'b00, 0, U1, 2'b00, 2'b00, 0,  1, 2'b00, 2'b00, 0, 0,   0, 0, 0);
    add(2'b10, 2'b00, 0, U1, 2'b10, 2'b00, AD, 1, 2'b10, 2'b00, 0, 0,   0, 0, 0);
    add(2'b10, 2'b00, 0, U2, 2'b10, 2'b00, AD, 1, 2'b10, 2'b00, 0, 0,   0, 0, 0);
    add(2'b10, 2'b10, 0, U3, 2'b10, 2'b00, AD, 1, 2'b10, 2'b00, 0, 0,   0, 1, 0);
    add(2'b10, 2'b10, 0, N1, 2'b00, 2'b00, 0,  1, 2'b00, 2'b00, 0, 0,   0, 0, 0);
    add(2'b10, 2'b10, 0, N1, 2'b00, 2'b00, 0,  1, 2'b10, 2'b00, 1, N1T, 1, 0, 0);
    add(2'b00, 2'b00, 0, 0,  2'b00, 2'b00, 0,  1, 2'b00, 2'b00, 0, 0,   0, 0, 0);

    rst_n = 1'b0; rst2_n = 1'b0;
    hv = '0; hl = '0; hd = '0; hk = 16'hFFFF; dv = '0; dl = '0; dd = '0; dk = 16'hFFFF; ordy = 1'b1;
    hv2 = '0; hl2 = '0; hd2 = '0; hk2 = '0; dv2 = '0; dl2 = '0; dd2 = '0; dk2 = '0; ordy2 = 1'b1;
    #12;
    chk("reset valid", ov, 0);
    chk("reset data", od, 0);
    chk("reset keep", ok, 0);
    chk("reset last", ol, 0);
    chk("reset err_unsup", eu, 0);
    chk("reset err_len", el, 0);
    chk("reset hdr_ready", hr, 0);
    chk("reset dat_ready", dr, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1; rst2_n = 1'b1;

    for (int i = 0; i < n_rows; i++) begin
      @(negedge clk);
      hv = vec[i].hv; hl = vec[i].hl; hd = {vec[i].hd1, vec[i].hd0};
      dv = vec[i].dv; dl = vec[i].dl; dd = {vec[i].dd, vec[i].dd}; ordy = vec[i].ordy;
      #3;
      chk($sformatf("row%0d hdr_ready", i), hr, vec[i].hr);
      chk($sformatf("row%0d dat_ready", i), dr, vec[i].dr);
      @(posedge clk); #1;
      chk($sformatf("row%0d valid", i), ov, vec[i].ov);
      if (vec[i].ov) begin
        chk($sformatf("row%0d data", i), od, vec[i].od);
        chk($sformatf("row%0d keep", i), ok, 8'hFF);
        chk($sformatf("row%0d last", i), ol, vec[i].ol);
      end
      chk($sformatf("row%0d err_unsup", i), eu, vec[i].eu);
      chk($sformatf("row%0d err_len", i), el, vec[i].el);
    end

    // 128-bit: MRd len=4 with only 2 DW of data
    @(negedge clk);
    hv2 = 2'b01; hl2 = 2'b01; hd2[127:0] = H128; hk2[15:0] = 16'h0FFF;
    @(posedge clk); #1;
    chk("w128 grant bubble", ov2, 0);
    @(negedge clk); #3;
    chk("w128 hdr_ready", hr2, 2'b01);
    @(posedge clk); #1;
    chk("w128 hdr valid", ov2, 1);
    chk("w128 hdr data", od2, H128T);
    chk("w128 hdr keep", ok2, 16'h0FFF);
    chk("w128 hdr last", ol2, 0);
    @(negedge clk);
    hv2 = '0; hl2 = '0; dv2 = 2'b01; dl2 = 2'b01; dd2[127:0] = D128; dk2[15:0] = 16'h00FF;
    #3;
    chk("w128 dat_ready", dr2, 2'b01);
    @(posedge clk); #1;
    chk("w128 dat valid", ov2, 1);
    chk("w128 dat data", od2, D128);
    chk("w128 dat keep", ok2, 16'h00FF);
    chk("w128 dat last", ol2, 1);
    chk("w128 err_len pulse", el2, 1);
    @(negedge clk);
    dv2 = '0; dl2 = '0;
    @(posedge clk); #1;
    chk("w128 err_len clear", el2, 0);
    chk("w128 idle valid", ov2, 0);

    // second packet, reset while in DATA
    @(negedge clk);
    hv2 = 2'b01; hl2 = 2'b01; hd2[127:0] = H128;
    @(posedge clk); @(negedge clk);
    @(posedge clk); #1;
    chk("rst hdr out", ov2, 1);
    @(negedge clk);
    hv2 = '0; hl2 = '0; dv2 = 2'b01; dl2 = 2'b00; dd2[127:0] = D128;
    @(posedge clk); #1;
    chk("rst dat out", ov2, 1);
    @(negedge clk); #2;
    rst2_n = 1'b0;
    #1;
    chk("rst valid clears", ov2, 0);
    chk("rst dat_ready clears", dr2, 0);
    chk("rst data clears", od2, 0);
    dv2 = '0;
    @(negedge clk);
    rst2_n = 1'b1;
    hv2 = 2'b11; hl2 = 2'b11; hd2 = {W1, W0}; hk2 = 32'h00FF_00FF;
    @(posedge clk); @(negedge clk); #3;
    chk("rst pointer grant", hr2, 2'b01);
    @(posedge clk); #1;
    chk("rst pointer data", od2, W0T);
    @(negedge clk);
    hv2 = '0; hl2 = '0;
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
